// File: rtl/sr_imem_pkg.sv
// Shared types and constants for the sr_cpu instruction-memory loader.
package sr_imem_pkg;

  // Loader FSM states: HOLD (no program), LOAD (streaming bytes), RUN (CPU released)
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } imem_state_t;

  // addi x0,x0,0 returned for fetches beyond the memory
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  // Word-index width for a memory of the given depth
  function automatic int imem_aw(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sr_imem_ram.sv
// DEPTH x 32 instruction array: one synchronous write port, one asynchronous
// read port. Kept separate so a vendor RAM macro can replace it.
module sr_imem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Synchronous write port; contents are intentionally not reset
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sr_imem_loader.sv
// Instruction memory for sr_cpu with a byte-serial program load port.
// Bytes are assembled little-endian into 32-bit words written from word 0;
// the CPU is held in reset until a complete load has finished.
module sr_imem_loader
  import sr_imem_pkg::*;
#(
  parameter int          DEPTH    = 1024,
  parameter logic [31:0] NOP_WORD = IMEM_NOP
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr_addr,
  output logic [31:0]              instr_data,
  input  logic                     load_start,
  input  logic                     load_end,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     cpu_rst,
  output logic [$clog2(DEPTH):0]   load_words,
  output logic                     load_overflow
);

  localparam int AW = imem_aw(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_PTR = CW'(DEPTH);

  imem_state_t   r_state;
  logic [CW-1:0] r_ptr;
  logic [1:0]    r_lane;
  logic [31:0]   r_buf;
  logic          r_cpu_rst;
  logic          r_byte_ready;
  logic          r_overflow;

  logic          w_in_load;
  logic          w_acc;
  logic          w_full;
  logic [31:0]   w_word;
  logic [1:0]    w_lane_nxt;
  logic [31:0]   w_buf_nxt;
  logic          w_word_done;
  logic          w_fin;
  logic          w_we;
  logic [31:0]   w_wdata;
  logic          w_ovf_set;
  logic [CW-1:0] w_ptr_nxt;
  logic [31:0]   w_rdata;

  // A restart in the same cycle wins, so bytes and load_end are ignored then
  assign w_in_load = (r_state == LOAD) && !load_start;
  assign w_acc     = w_in_load && byte_valid;
  assign w_full    = (r_ptr == FULL_PTR);
  assign w_word    = r_buf | ({24'd0, byte_data} << {r_lane, 3'b000});

  // Byte lane advance and word assembly for an accepted byte
  always_comb begin
    w_lane_nxt  = r_lane;
    w_buf_nxt   = r_buf;
    w_word_done = 1'b0;
    if (w_acc && (r_lane == 2'd3)) begin
      w_lane_nxt  = 2'd0;
      w_buf_nxt   = 32'd0;
      w_word_done = 1'b1;
    end else if (w_acc) begin
      w_lane_nxt  = r_lane + 2'd1;
      w_buf_nxt   = w_word;
      w_word_done = 1'b0;
    end else begin
      w_lane_nxt  = r_lane;
      w_buf_nxt   = r_buf;
      w_word_done = 1'b0;
    end
  end

  // load_end flushes a partial word using the lane state after this cycle's byte,
  // so a completed 4th byte never produces an extra zero word
  assign w_fin     = w_in_load && load_end && (w_lane_nxt != 2'd0);
  assign w_we      = (w_word_done || w_fin) && !w_full && !rst;
  assign w_wdata   = w_word_done ? w_word : w_buf_nxt;
  assign w_ovf_set = (w_acc || w_fin) && w_full;
  assign w_ptr_nxt = w_we ? (r_ptr + CW'(1)) : r_ptr;

  // Loader FSM with registered handshake, CPU reset and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HOLD;
      r_cpu_rst    <= 1'b1;
      r_byte_ready <= 1'b0;
      r_ptr        <= '0;
      r_lane       <= 2'd0;
      r_buf        <= 32'd0;
      r_overflow   <= 1'b0;
    end else if (load_start) begin
      r_state      <= LOAD;
      r_cpu_rst    <= 1'b1;
      r_byte_ready <= 1'b1;
      r_ptr        <= '0;
      r_lane       <= 2'd0;
      r_buf        <= 32'd0;
      r_overflow   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_ptr <= w_ptr_nxt;
          if (w_ovf_set) begin
            r_overflow <= 1'b1;
          end
          if (load_end) begin
            r_state      <= RUN;
            r_cpu_rst    <= 1'b0;
            r_byte_ready <= 1'b0;
            r_lane       <= 2'd0;
            r_buf        <= 32'd0;
          end else begin
            r_state      <= LOAD;
            r_cpu_rst    <= 1'b1;
            r_byte_ready <= 1'b1;
            r_lane       <= w_lane_nxt;
            r_buf        <= w_buf_nxt;
          end
        end
        RUN: begin
          r_state      <= RUN;
          r_cpu_rst    <= 1'b0;
          r_byte_ready <= 1'b0;
        end
        HOLD: begin
          r_state      <= HOLD;
          r_cpu_rst    <= 1'b1;
          r_byte_ready <= 1'b0;
        end
        default: begin
          r_state      <= HOLD;
          r_cpu_rst    <= 1'b1;
          r_byte_ready <= 1'b0;
        end
      endcase
    end
  end

  sr_imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_ptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (instr_addr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // Combinational fetch: out-of-range word indices return a NOP
  always_comb begin
    if (instr_addr < 32'(DEPTH)) begin
      instr_data = w_rdata;
    end else begin
      instr_data = NOP_WORD;
    end
  end

  assign byte_ready    = r_byte_ready;
  assign cpu_rst       = r_cpu_rst;
  assign load_words    = r_ptr;
  assign load_overflow = r_overflow;

endmodule

// File: tb/tb_sr_imem_loader.sv
// Self-checking bench for sr_imem_loader: directed scenarios followed by
// random traffic, all compared against a byte-queue reference model.
module tb_sr_imem_loader;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   instr_addr = 32'd0;
  logic [31:0]   instr_data;
  logic          load_start = 1'b0;
  logic          load_end = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          byte_ready;
  logic          cpu_rst;
  logic [CW-1:0] load_words;
  logic          load_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: the bytes of the current load plus known memory words
  logic [7:0]  m_q [$];
  logic [31:0] m_mem [DEPTH];
  bit          m_ok [DEPTH];
  bit          m_in_load = 1'b0;
  bit          m_run = 1'b0;
  int          m_lw = 0;
  bit          m_ovf = 1'b0;

  always #5 clk = ~clk;

  sr_imem_loader #(
    .DEPTH    (DEPTH),
    .NOP_WORD (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_addr    (instr_addr),
    .instr_data    (instr_data),
    .load_start    (load_start),
    .load_end      (load_end),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .cpu_rst       (cpu_rst),
    .load_words    (load_words),
    .load_overflow (load_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Word i of the current load, zero-padded past the last byte
  function automatic logic [31:0] word_at(input int i);
    logic [31:0] w;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (4 * i + k < m_q.size()) w[8*k +: 8] = m_q[4*i + k];
    end
    return w;
  endfunction

  task automatic model_edge(input bit ls, input bit le, input bit bv, input logic [7:0] bd, input bit r);
    int n;
    int nw;
    if (r) begin
      m_in_load = 1'b0; m_run = 1'b0; m_q.delete(); m_lw = 0; m_ovf = 1'b0;
    end else if (ls) begin
      m_in_load = 1'b1; m_run = 1'b0; m_q.delete(); m_lw = 0; m_ovf = 1'b0;
    end else if (m_in_load) begin
      if (bv) begin
        m_q.push_back(bd);
        n = m_q.size();
        if (n > 4 * DEPTH) m_ovf = 1'b1;
        else if (n % 4 == 0) begin
          m_mem[n/4 - 1] = word_at(n/4 - 1);
          m_ok[n/4 - 1]  = 1'b1;
        end
        m_lw = imin(n / 4, DEPTH);
      end
      if (le) begin
        n  = m_q.size();
        nw = (n + 3) / 4;
        if (n % 4 != 0) begin
          if (nw <= DEPTH) begin
            m_mem[nw - 1] = word_at(nw - 1);
            m_ok[nw - 1]  = 1'b1;
          end else m_ovf = 1'b1;
        end
        m_lw = imin(nw, DEPTH);
        m_in_load = 1'b0;
        m_run = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    chk("cpu_rst", {31'd0, cpu_rst}, {31'd0, !m_run});
    chk("byte_ready", {31'd0, byte_ready}, {31'd0, m_in_load});
    chk("load_words", 32'(load_words), 32'(m_lw));
    chk("load_overflow", {31'd0, load_overflow}, {31'd0, m_ovf});
    if (instr_addr >= 32'(DEPTH)) chk("instr_nop", instr_data, 32'h0000_0013);
    else if (m_ok[instr_addr[CW-2:0]]) chk("instr_data", instr_data, m_mem[instr_addr[CW-2:0]]);
  endtask

  // One clock: drive inputs, update the model at the edge, check after it
  task automatic step(input bit ls, input bit le, input bit bv, input logic [7:0] bd, input bit r);
    int pick;
    rst = r; load_start = ls; load_end = le; byte_valid = bv; byte_data = bd;
    @(posedge clk);
    model_edge(ls, le, bv, bd, r);
    #1;
    rst = 1'b0; load_start = 1'b0; load_end = 1'b0; byte_valid = 1'b0;
    pick = int'($urandom_range(0, 9));
    if (pick < 8) instr_addr = 32'(pick);
    else instr_addr = $urandom;
    #1;
    check_outputs();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b0, 1'b1, b, 1'b0);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    instr_addr = a;
    #1;
    chk(tag, instr_data, exp);
  endtask

  initial begin
    logic [7:0] basic [8];
    basic = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 32'd0;
      m_ok[i]  = 1'b0;
    end
    #2;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_load_words", 32'(load_words), 32'd0);
    step(1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
    chk("hold_ignores_end", {31'd0, cpu_rst}, 32'd1);

    // Basic two-word load
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("load_entry_ready", {31'd0, byte_ready}, 32'd1);
    for (int i = 0; i < 8; i++) send(basic[i]);
    chk("load_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("basic_cpu_run", {31'd0, cpu_rst}, 32'd0);
    chk("basic_lw", 32'(load_words), 32'd2);
    read_chk("basic_w0", 32'd0, 32'h0050_0013);
    read_chk("basic_w1", 32'd1, 32'h0010_0093);
    read_chk("basic_nop", 32'(DEPTH), 32'h0000_0013);
    read_chk("basic_nop_hi", 32'hFFFF_FFFF, 32'h0000_0013);

    // Partial final word
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'hEE);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("partial_lw", 32'(load_words), 32'd2);
    read_chk("partial_w0", 32'd0, 32'hDDCC_BBAA);
    read_chk("partial_w1", 32'd1, 32'h0000_00EE);

    // 4th byte together with load_end
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    send(8'h12); send(8'h34); send(8'h56);
    step(1'b0, 1'b1, 1'b1, 8'h78, 1'b0);
    chk("simul_lw", 32'(load_words), 32'd1);
    chk("simul_run", {31'd0, cpu_rst}, 32'd0);
    read_chk("simul_w0", 32'd0, 32'h7856_3412);
    read_chk("simul_w1_kept", 32'd1, 32'h0000_00EE);

    // Overflow: 20 bytes into 4 words
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) send(8'(i));
    chk("ovf_flag", {31'd0, load_overflow}, 32'd1);
    chk("ovf_lw", 32'(load_words), 32'd4);
    chk("ovf_ready", {31'd0, byte_ready}, 32'd1);
    read_chk("ovf_w3", 32'd3, 32'h0F0E_0D0C);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk("ovf_sticky_run", {31'd0, load_overflow}, 32'd1);

    // Reload from RUN clears status and overwrites word 0 only
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("reload_lw", 32'(load_words), 32'd0);
    chk("reload_ovf_clr", {31'd0, load_overflow}, 32'd0);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    read_chk("reload_w0", 32'd0, 32'hA4A3_A2A1);
    read_chk("reload_w1_old", 32'd1, 32'h0706_0504);

    // Reset in the middle of a load
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    send(8'h11); send(8'h22);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("midrst_ready", {31'd0, byte_ready}, 32'd0);
    chk("midrst_lw", 32'(load_words), 32'd0);
    send(8'h33);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("midrst_no_run", {31'd0, cpu_rst}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 30) == 0, ($urandom % 12) == 0, ($urandom % 3) != 0,
           8'($urandom), ($urandom % 150) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
